// File: rtl/tisc_pkg.sv
// Shared definitions for the TISC multi-cycle controller: opcodes, ALU encodings, FSM states.
package tisc_pkg;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpLd  = 4'h4;
  localparam logic [3:0] OpSt  = 4'h5;
  localparam logic [3:0] OpBeq = 4'h6;
  localparam logic [3:0] OpJmp = 4'h7;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOr  = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu, ClsLd, ClsSt, ClsBeq, ClsJmp, ClsNop, ClsHlt
  } op_class_e;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier for the multi-cycle controller.
module op_decode
  import tisc_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = ClsNop;
    case (opcode)
      OpAdd, OpSub, OpAnd, OpOr: op_class = ClsAlu;
      OpLd:                      op_class = ClsLd;
      OpSt:                      op_class = ClsSt;
      OpBeq:                     op_class = ClsBeq;
      OpJmp:                     op_class = ClsJmp;
      OpHlt:                     op_class = ClsHlt;
      default:                   op_class = ClsNop;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer sharing one memory port via req/ack.
module multicycle_cu
  import tisc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_op,
  output logic             mem_write_en,
  output logic             mem_to_reg,
  output logic             reg_write_en,
  output logic [1:0]       alu_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic [3:0]       decode_op;
  op_class_e        cls;

  // In DECODE the live opcode is classified; afterwards the latched copy is used.
  assign decode_op = (state_q == StDecode) ? opcode : op_q;

  op_decode u_op_decode (
    .opcode   (decode_op),
    .op_class (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= 4'h0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_op       = 1'b0;
    mem_write_en = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write_en = 1'b0;
    alu_sel      = AluAdd;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        case (cls)
          ClsAlu, ClsBeq, ClsJmp: state_d = StExec;
          ClsLd, ClsSt:           state_d = StMem;
          ClsHlt: begin
            retire  = 1'b1;
            state_d = StHalt;
          end
          default: begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        endcase
      end

      StExec: begin
        case (cls)
          ClsAlu: begin
            alu_sel = op_q[1:0];
            state_d = StWb;
          end
          ClsBeq: begin
            alu_sel = AluSub;
            pc_load = zero;
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: begin
            pc_load = (cls == ClsJmp);
            retire  = 1'b1;
            state_d = StFetch;
          end
        endcase
      end

      StMem: begin
        mem_req      = 1'b1;
        mem_op       = 1'b1;
        mem_write_en = (cls == ClsSt);
        if (mem_ack) begin
          if (cls == ClsSt) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        reg_write_en = 1'b1;
        mem_to_reg   = (cls == ClsLd);
        alu_sel      = (cls == ClsAlu) ? op_q[1:0] : AluAdd;
        retire       = 1'b1;
        state_d      = StFetch;
      end

      StHalt: halted = 1'b1;

      default: state_d = StIdle;
    endcase
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: directed table, random programs against a per-instruction trace model.
module tb_multicycle_cu;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    opcode = 4'h0;
  logic          zero = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_op, mem_write_en, mem_to_reg, reg_write_en;
  logic [1:0]    alu_sel;
  logic          ir_load, pc_inc, pc_load, halted;
  logic [CW-1:0] retired;
  logic [10:0]   dut_out;

  multicycle_cu #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_op       (mem_op),
    .mem_write_en (mem_write_en),
    .mem_to_reg   (mem_to_reg),
    .reg_write_en (reg_write_en),
    .alu_sel      (alu_sel),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .halted       (halted),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  assign dut_out = {mem_req, mem_op, mem_write_en, mem_to_reg, reg_write_en, alu_sel,
                    ir_load, pc_inc, pc_load, halted};

  typedef struct {
    logic        ack;
    logic [10:0] out;
    bit          retire;
  } cyc_t;

  typedef struct {
    logic [3:0] op;
    int         fw, mw;
    bit         z;
    int         cyc, rwe, pcl, mwe, m2r;
  } dir_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  function automatic logic [10:0] pk(bit req, bit mop, bit mwe, bit m2r, bit rwe,
                                     logic [1:0] alu, bit irl, bit pinc, bit pcl, bit hlt);
    return {req, mop, mwe, m2r, rwe, alu, irl, pinc, pcl, hlt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle trace of one instruction, built from the instruction-level rules.
  function automatic void gen(logic [3:0] op, int fw, int mw, bit z);
    logic [1:0] f = op[1:0];
    for (int i = 0; i < fw; i++) q.push_back('{1'b0, pk(1,0,0,0,0,2'b00,0,0,0,0), 0});
    q.push_back('{1'b1, pk(1,0,0,0,0,2'b00,1,1,0,0), 0});
    q.push_back('{1'($urandom), 11'd0, op >= 4'h8});
    if (op < 4'h4) begin
      q.push_back('{1'($urandom), pk(0,0,0,0,0,f,0,0,0,0), 0});
      q.push_back('{1'($urandom), pk(0,0,0,0,1,f,0,0,0,0), 1});
    end else if (op == 4'h4 || op == 4'h5) begin
      bit st = (op == 4'h5);
      for (int i = 0; i < mw; i++) q.push_back('{1'b0, pk(1,1,st,0,0,2'b00,0,0,0,0), 0});
      q.push_back('{1'b1, pk(1,1,st,0,0,2'b00,0,0,0,0), st});
      if (!st) q.push_back('{1'($urandom), pk(0,0,0,1,1,2'b00,0,0,0,0), 1});
    end else if (op == 4'h6) begin
      q.push_back('{1'($urandom), pk(0,0,0,0,0,2'b01,0,0,z,0), 1});
    end else if (op == 4'h7) begin
      q.push_back('{1'($urandom), pk(0,0,0,0,0,2'b00,0,0,1,0), 1});
    end
  endfunction

  task automatic play(input logic [3:0] op, input bit z);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode  = op;
      zero    = z;
      mem_ack = c.ack;
      @(negedge clk);
      check($sformatf("outputs op%0h", op), dut_out, c.out);
      check($sformatf("retired op%0h", op), retired, model_cnt);
      if (c.retire) model_cnt = (model_cnt + 1) % 16;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset outputs", dut_out, 0);
    check("reset retired", retired, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    check("idle outputs", dut_out, 0);
    check("idle retired", retired, 0);
    @(posedge clk);
    #1;
  endtask

  // Drives ack by watching the request, counts strobes until the retire edge.
  task automatic run_dir(input dir_t d);
    int   cyc = 0, fcnt = 0, mcnt = 0, rwe = 0, pcl = 0, mwe = 0, m2r = 0;
    bit   done = 0;
    logic [CW-1:0] r0 = retired;
    opcode = d.op;
    zero   = d.z;
    while (!done && cyc < 40) begin
      mem_ack = 1'b0;
      if (mem_req && !mem_op) begin
        mem_ack = (fcnt >= d.fw);
        fcnt++;
      end else if (mem_req && mem_op) begin
        mem_ack = (mcnt >= d.mw);
        mcnt++;
      end
      @(negedge clk);
      rwe += int'(reg_write_en);
      pcl += int'(pc_load);
      mwe += int'(mem_write_en);
      m2r += int'(mem_to_reg);
      cyc++;
      @(posedge clk);
      #1;
      if (retired != r0) done = 1;
    end
    check($sformatf("dir op%0h cycles", d.op), cyc, d.cyc);
    check($sformatf("dir op%0h reg_write_en", d.op), rwe, d.rwe);
    check($sformatf("dir op%0h pc_load", d.op), pcl, d.pcl);
    check($sformatf("dir op%0h mem_write_en", d.op), mwe, d.mwe);
    check($sformatf("dir op%0h mem_to_reg", d.op), m2r, d.m2r);
  endtask

  initial begin
    dir_t tbl[10];
    //          op    fw mw z  cyc rwe pcl mwe m2r
    tbl[0] = '{4'h0, 0, 0, 0, 4, 1, 0, 0, 0};
    tbl[1] = '{4'h4, 0, 3, 0, 7, 1, 0, 0, 1};
    tbl[2] = '{4'h5, 0, 0, 0, 3, 0, 0, 1, 0};
    tbl[3] = '{4'h6, 0, 0, 1, 3, 0, 1, 0, 0};
    tbl[4] = '{4'h6, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[5] = '{4'h7, 2, 0, 0, 5, 0, 1, 0, 0};
    tbl[6] = '{4'h9, 1, 0, 0, 3, 0, 0, 0, 0};
    tbl[7] = '{4'h1, 1, 0, 0, 5, 1, 0, 0, 0};
    tbl[8] = '{4'h3, 0, 0, 0, 4, 1, 0, 0, 0};
    tbl[9] = '{4'h5, 0, 2, 0, 5, 0, 0, 3, 0};

    #2;
    do_reset();

    foreach (tbl[i]) run_dir(tbl[i]);
    check("retired after table", retired, 10);
    model_cnt = 10;

    for (int n = 0; n < 60; n++) begin
      logic [3:0] op = 4'($urandom_range(0, 14));
      bit         z  = 1'($urandom);
      gen(op, $urandom_range(0, 3), $urandom_range(0, 3), z);
      play(op, z);
    end

    gen(4'hF, 1, 0, 0);
    play(4'hF, 0);
    for (int n = 0; n < 6; n++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      check("halt outputs", dut_out, pk(0,0,0,0,0,2'b00,0,0,0,1));
      check("halt retired", retired, model_cnt);
      @(posedge clk);
      #1;
    end

    do_reset();
    mem_ack = 1'b0;
    @(negedge clk);
    check("fetch wait outputs", dut_out, pk(1,0,0,0,0,2'b00,0,0,0,0));
    @(posedge clk);
    #3;
    do_reset();

    for (int n = 0; n < 17; n++) begin
      logic [3:0] op = 4'(8 + (n % 7));
      gen(op, 0, 0, 0);
      play(op, 0);
      if (n == 14) check("wrap at 15", retired, 15);
      if (n == 15) check("wrap to 0", retired, 0);
      if (n == 16) check("wrap to 1", retired, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
